// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// One request per handshake; the response arrives later on data_data_ok.

interface mem_access_if #(
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [DATA_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        output data_wstrb,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        input  data_wstrb,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the dual-issue pipeline: issues data-memory requests for lane-1
// loads/stores, aligns load data into lane-1 write-back and flags address errors.

module mem_access #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_stall_i,
    input  logic [DATA_W-1:0] inst1_addr_i,
    input  logic [DATA_W-1:0] inst2_addr_i,
    input  logic [4:0]        waddr1_i,
    input  logic [4:0]        waddr2_i,
    input  logic              we1_i,
    input  logic              we2_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] wdata2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              whilo_i,
    input  logic [7:0]        aluop1_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    mem_access_if.master      dmem,
    output logic [DATA_W-1:0] inst1_addr_o,
    output logic [DATA_W-1:0] inst2_addr_o,
    output logic [4:0]        waddr1_o,
    output logic [4:0]        waddr2_o,
    output logic              we1_o,
    output logic              we2_o,
    output logic [DATA_W-1:0] wdata1_o,
    output logic [DATA_W-1:0] wdata2_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              stallreq_o,
    output logic              exc_adel_o,
    output logic              exc_ades_o,
    output logic [DATA_W-1:0] badvaddr_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] result_r;

    logic              is_load_s;
    logic              is_store_s;
    logic              sext_s;
    logic [1:0]        size_s;
    logic              misalign_s;
    logic              go_s;
    logic              addr_err_s;
    logic [DATA_W-1:0] load_data_s;
    logic              data_req_s;
    logic              stall_s;
    logic [DATA_W-1:0] wdata1_s;

    // Pick the addressed byte/half out of a little-endian word and extend it.
    function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Replicate store data across every lane so any strobe pattern finds it.
    function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                                input logic [31:0] r2);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{r2[7:0]}};
            SZ_HALF: w = {2{r2[15:0]}};
            default: w = r2;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [1:0] size,
                                               input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            SZ_BYTE: begin
                case (lo)
                    2'd0:    s = 4'b0001;
                    2'd1:    s = 4'b0010;
                    2'd2:    s = 4'b0100;
                    default: s = 4'b1000;
                endcase
            end
            SZ_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Decode the lane-1 op into access direction, size and signedness.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sext_s     = 1'b0;
        size_s     = SZ_WORD;
        case (aluop1_i)
            EXE_LB_OP:  begin is_load_s  = 1'b1; size_s = SZ_BYTE; sext_s = 1'b1; end
            EXE_LBU_OP: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            EXE_LH_OP:  begin is_load_s  = 1'b1; size_s = SZ_HALF; sext_s = 1'b1; end
            EXE_LHU_OP: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            EXE_LW_OP:  begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            EXE_SB_OP:  begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            EXE_SH_OP:  begin is_store_s = 1'b1; size_s = SZ_HALF; end
            EXE_SW_OP:  begin is_store_s = 1'b1; size_s = SZ_WORD; end
            default:    begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    // Natural alignment check for the decoded access size.
    always_comb begin
        misalign_s = 1'b0;
        case (size_s)
            SZ_HALF: misalign_s = mem_addr_i[0];
            SZ_WORD: misalign_s = (mem_addr_i[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // A flushed op is dead: it neither requests nor raises an address error.
    assign go_s        = (is_load_s | is_store_s) & ~misalign_s & ~flush;
    assign addr_err_s  = (is_load_s | is_store_s) & misalign_s & ~flush & ~rst;
    assign load_data_s = load_align(dmem.data_rdata, mem_addr_i[1:0], size_s, sext_s);

    // Access sequencer; result_r keeps load data while a later stage holds MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s && dmem.data_addr_ok) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem.data_data_ok) begin
                        if (flush) begin
                            state_r <= ST_IDLE;
                        end else begin
                            if (is_load_s) begin
                                result_r <= load_data_s;
                            end
                            state_r <= mem_stall_i ? ST_DONE : ST_IDLE;
                        end
                    end else if (flush) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || !mem_stall_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dmem.data_data_ok) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Request, stall and lane-1 result selection derived from the sequencer state.
    always_comb begin
        data_req_s = 1'b0;
        stall_s    = 1'b0;
        wdata1_s   = wdata1_i;
        if (rst) begin
            data_req_s = 1'b0;
            stall_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_req_s = go_s;
                    stall_s    = go_s;
                end
                ST_WAIT: begin
                    stall_s = ~dmem.data_data_ok;
                    if (dmem.data_data_ok && !flush && is_load_s) begin
                        wdata1_s = load_data_s;
                    end else begin
                        wdata1_s = wdata1_i;
                    end
                end
                ST_DONE: begin
                    if (is_load_s) begin
                        wdata1_s = result_r;
                    end else begin
                        wdata1_s = wdata1_i;
                    end
                end
                ST_DRAIN: begin
                    stall_s = 1'b1;
                end
                default: begin
                    data_req_s = 1'b0;
                    stall_s    = 1'b0;
                end
            endcase
        end
    end

    assign dmem.data_req   = data_req_s;
    assign dmem.data_wr    = is_store_s;
    assign dmem.data_size  = size_s;
    assign dmem.data_addr  = mem_addr_i;
    assign dmem.data_wdata = store_wdata(size_s, reg2_i);
    assign dmem.data_wstrb = is_store_s ? store_wstrb(size_s, mem_addr_i[1:0]) : 4'b0000;

    assign stallreq_o = stall_s;
    assign exc_adel_o = addr_err_s & is_load_s;
    assign exc_ades_o = addr_err_s & is_store_s;
    assign badvaddr_o = addr_err_s ? mem_addr_i : '0;

    assign inst1_addr_o = inst1_addr_i;
    assign inst2_addr_o = inst2_addr_i;
    assign waddr1_o     = waddr1_i;
    assign waddr2_o     = waddr2_i;
    assign we1_o        = we1_i & ~addr_err_s;
    assign we2_o        = we2_i;
    assign wdata1_o     = wdata1_s;
    assign wdata2_o     = wdata2_i;
    assign hi_o         = hi_i;
    assign lo_o         = lo_i;
    assign whilo_o      = whilo_i;

endmodule

// File: tb/tb_mem_access.sv
// Directed plus randomized bench for mem_access; expectations come from an
// arithmetic model of load/store lane rules and cycle-count timing of each access.

module tb_mem_access;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst, flush, mem_stall_i;
    logic [31:0] inst1_addr_i, inst2_addr_i, wdata1_i, wdata2_i, hi_i, lo_i, mem_addr_i, reg2_i;
    logic [4:0]  waddr1_i, waddr2_i;
    logic        we1_i, we2_i, whilo_i;
    logic [7:0]  aluop1_i;
    logic [31:0] inst1_addr_o, inst2_addr_o, wdata1_o, wdata2_o, hi_o, lo_o, badvaddr_o;
    logic [4:0]  waddr1_o, waddr2_o;
    logic        we1_o, we2_o, whilo_o, stallreq_o, exc_adel_o, exc_ades_o;

    int n_vec = 0;
    int n_err = 0;

    mem_access_if bus ();

    mem_access dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_stall_i(mem_stall_i),
        .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
        .waddr1_i(waddr1_i), .waddr2_i(waddr2_i), .we1_i(we1_i), .we2_i(we2_i),
        .wdata1_i(wdata1_i), .wdata2_i(wdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .whilo_i(whilo_i), .aluop1_i(aluop1_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .dmem(bus),
        .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
        .waddr1_o(waddr1_o), .waddr2_o(waddr2_o), .we1_o(we1_o), .we2_o(we2_o),
        .wdata1_o(wdata1_o), .wdata2_o(wdata2_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .stallreq_o(stallreq_o), .exc_adel_o(exc_adel_o),
        .exc_ades_o(exc_ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic int bytes_of(input logic [7:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    // Expected load result: shift the addressed field down, mask, subtract 2^n if signed and negative.
    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int nb;
        nb = bytes_of(op);
        if (nb == 4) return rd;
        v = rd >> (32'(addr % 32'd4) * 32'd8);
        if (nb == 1) begin
            v = v & 32'h0000_00FF;
            if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
        end else begin
            v = (rd >> (32'(addr % 32'd4) / 32'd2 * 32'd16)) & 32'h0000_FFFF;
            if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] r2);
        if (bytes_of(op) == 1) return (r2 & 32'h0000_00FF) * 32'h0101_0101;
        if (bytes_of(op) == 2) return (r2 & 32'h0000_FFFF) * 32'h0001_0001;
        return r2;
    endfunction

    function automatic logic [31:0] model_wstrb(input logic [7:0] op, input logic [31:0] addr);
        logic [31:0] ones;
        if (!is_store_op(op)) return 32'd0;
        ones = (32'd1 << bytes_of(op)) - 32'd1;
        return ones << (addr % 32'd4);
    endfunction

    task automatic rand_lanes();
        inst1_addr_i = $urandom; inst2_addr_i = $urandom;
        waddr1_i = 5'($urandom); waddr2_i = 5'($urandom);
        we2_i = 1'($urandom); wdata2_i = $urandom;
        hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
    endtask

    task automatic chk_lanes();
        chk("inst1_addr", inst1_addr_o, inst1_addr_i);
        chk("inst2_addr", inst2_addr_o, inst2_addr_i);
        chk("waddr1", 32'(waddr1_o), 32'(waddr1_i));
        chk("waddr2", 32'(waddr2_o), 32'(waddr2_i));
        chk("we2", 32'(we2_o), 32'(we2_i));
        chk("wdata2", wdata2_o, wdata2_i);
        chk("hi", hi_o, hi_i);
        chk("lo", lo_o, lo_i);
        chk("whilo", 32'(whilo_o), 32'(whilo_i));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // One complete access: accept after a_lat cycles, respond d_lat later, then ms held cycles.
    task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd,
                              input logic [31:0] r2, input int a_lat, input int d_lat, input int ms,
                              input logic [31:0] exp_ld);
        int  c_done;
        logic ld;
        c_done = a_lat + d_lat;
        ld = is_load_op(op);
        aluop1_i = op; mem_addr_i = addr; reg2_i = r2; wdata1_i = $urandom; we1_i = 1'b1;
        flush = 1'b0;
        rand_lanes();
        for (int c = 0; c <= c_done + ms; c++) begin
            bus.data_addr_ok = (c == a_lat);
            bus.data_data_ok = (c == c_done);
            bus.data_rdata   = (c == c_done) ? rd : $urandom;
            mem_stall_i      = (c >= c_done) && (c < c_done + ms);
            @(negedge clk);
            chk("req", 32'(bus.data_req), 32'(c <= a_lat));
            chk("stall", 32'(stallreq_o), 32'(c < c_done));
            if (c >= c_done) chk("wdata1", wdata1_o, ld ? exp_ld : wdata1_i);
            else             chk("wdata1_pend", wdata1_o, wdata1_i);
            if (c == 0) begin
                chk("wr", 32'(bus.data_wr), 32'(is_store_op(op)));
                chk("size", 32'(bus.data_size), 32'(bytes_of(op) / 2));
                chk("addr_word", 32'(bus.data_addr[31:2]), 32'(addr[31:2]));
                chk("wstrb", 32'(bus.data_wstrb), model_wstrb(op, addr));
                chk("we1", 32'(we1_o), 32'd1);
                chk("exc", 32'({exc_adel_o, exc_ades_o}), 32'd0);
                if (!ld) chk("wdata", bus.data_wdata, model_wdata(op, r2));
                chk_lanes();
            end
            advance();
        end
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; mem_stall_i = 1'b0;
    endtask

    initial begin
        logic [7:0]  ops [8];
        logic [7:0]  op;
        logic [31:0] addr, rd;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        rst = 1'b1; flush = 1'b0; mem_stall_i = 1'b0;
        aluop1_i = OP_LW; mem_addr_i = 32'h0000_0100; reg2_i = 32'd0;
        wdata1_i = 32'h0000_0055; we1_i = 1'b1;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        rand_lanes();

        // Reset: no request or stall even for an aligned load; pass-through alive.
        @(negedge clk);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_wdata1", wdata1_o, 32'h0000_0055);
        chk_lanes();
        mem_addr_i = 32'h0000_0102;
        #1;
        chk("rst_exc", 32'({exc_adel_o, exc_ades_o}), 32'd0);
        chk("rst_badvaddr", badvaddr_o, 32'd0);
        chk("rst_we1", 32'(we1_o), 32'd1);
        advance();
        rst = 1'b0;

        // Plain ALU op: pure pass-through over several cycles.
        aluop1_i = OP_ADD; wdata1_i = 32'h0000_0012; mem_addr_i = 32'h0000_0103;
        for (int i = 0; i < 3; i++) begin
            rand_lanes();
            @(negedge clk);
            chk("add_wdata1", wdata1_o, 32'h0000_0012);
            chk("add_req", 32'(bus.data_req), 32'd0);
            chk("add_stall", 32'(stallreq_o), 32'd0);
            chk_lanes();
            advance();
        end

        // Directed accesses with known answers.
        run_access(OP_LW, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1, 2, 0, 32'hDEAD_BEEF);
        run_access(OP_LB, 32'h0000_0103, 32'h80FF_0000, 32'd0, 0, 1, 0, 32'hFFFF_FF80);
        run_access(OP_LBU, 32'h0000_0103, 32'h80FF_0000, 32'd0, 0, 1, 0, 32'h0000_0080);

        // SH lane replication and upper-half strobes.
        aluop1_i = OP_SH; mem_addr_i = 32'h0000_0102; reg2_i = 32'h1234_ABCD;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("sh_req", 32'(bus.data_req), 32'd1);
        chk("sh_wr", 32'(bus.data_wr), 32'd1);
        chk("sh_size", 32'(bus.data_size), 32'd1);
        chk("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", 32'(bus.data_wstrb), 32'h0000_000C);
        advance();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        @(negedge clk);
        chk("sh_done_stall", 32'(stallreq_o), 32'd0);
        advance();
        bus.data_data_ok = 1'b0;

        // Misaligned load and store.
        aluop1_i = OP_LW; mem_addr_i = 32'h0000_0102; we1_i = 1'b1;
        @(negedge clk);
        chk("adel", 32'(exc_adel_o), 32'd1);
        chk("adel_ades", 32'(exc_ades_o), 32'd0);
        chk("adel_badvaddr", badvaddr_o, 32'h0000_0102);
        chk("adel_we1", 32'(we1_o), 32'd0);
        chk("adel_req", 32'(bus.data_req), 32'd0);
        chk("adel_stall", 32'(stallreq_o), 32'd0);
        advance();
        aluop1_i = OP_SW; mem_addr_i = 32'h0000_0101;
        @(negedge clk);
        chk("ades", 32'(exc_ades_o), 32'd1);
        chk("ades_adel", 32'(exc_adel_o), 32'd0);
        chk("ades_badvaddr", badvaddr_o, 32'h0000_0101);
        chk("ades_req", 32'(bus.data_req), 32'd0);
        advance();

        // Flush while waiting: drain the late response, discard it, return to idle.
        aluop1_i = OP_LW; mem_addr_i = 32'h0000_0200; wdata1_i = 32'hCAFE_0001;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_req", 32'(bus.data_req), 32'd1);
        advance();
        bus.data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_wait_stall", 32'(stallreq_o), 32'd1);
        advance();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_drain_stall", 32'(stallreq_o), 32'd1);
        chk("fl_drain_req", 32'(bus.data_req), 32'd0);
        advance();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("fl_discard", wdata1_o, 32'hCAFE_0001);
        chk("fl_drain_req2", 32'(bus.data_req), 32'd0);
        advance();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("fl_idle_req", 32'(bus.data_req), 32'd1);
        chk("fl_idle_stall", 32'(stallreq_o), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_idle_flush_req", 32'(bus.data_req), 32'd0);
        chk("fl_idle_flush_stall", 32'(stallreq_o), 32'd0);
        advance();
        flush = 1'b0;

        // Completion under a downstream hold: result held, no re-issue.
        run_access(OP_LW, 32'h0000_0300, 32'h5A5A_A5A5, 32'd0, 0, 1, 3, 32'h5A5A_A5A5);

        // Reset while waiting abandons the access.
        aluop1_i = OP_LW; mem_addr_i = 32'h0000_0400; bus.data_addr_ok = 1'b1;
        advance();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(stallreq_o), 32'd1);
        advance();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_stall", 32'(stallreq_o), 32'd0);
        chk("rw_rst_req", 32'(bus.data_req), 32'd0);
        advance();
        rst = 1'b0;
        run_access(OP_LHU, 32'h0000_0402, 32'h8765_4321, 32'd0, 1, 1, 0, 32'h0000_8765);

        // Randomized accesses against the model.
        for (int t = 0; t < 48; t++) begin
            op = ops[$urandom_range(0, 7)];
            addr = $urandom;
            if (bytes_of(op) == 4) addr = addr & 32'hFFFF_FFFC;
            if (bytes_of(op) == 2) addr = addr & 32'hFFFF_FFFE;
            rd = $urandom;
            run_access(op, addr, rd, $urandom, $urandom_range(0, 2), $urandom_range(1, 3),
                       $urandom_range(0, 2), model_load(op, addr, rd));
            aluop1_i = OP_ADD; wdata1_i = $urandom;
            rand_lanes();
            @(negedge clk);
            chk("rnd_gap_stall", 32'(stallreq_o), 32'd0);
            chk("rnd_gap_wdata1", wdata1_o, wdata1_i);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
